// File: rtl/timing_ctrl_seq_pkg.sv
// Shared types and defaults for the minor-cycle timing control sequencer.
// Mode and state encodings are used by the sequencer and its neighbours.
package edsac_timing_pkg;

  localparam int MC_LEN_DEFAULT   = 36;
  localparam int STEP_MAX_DEFAULT = 35;

  typedef enum logic [1:0] {
    MODE_MUL,
    MODE_SHR,
    MODE_SHL
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PH_A,
    ST_PH_B
  } state_e;

  // Multiply wins over shift; direction only matters for shifts.
  function automatic mode_e decode_mode(input logic c5, input logic shift_left);
    if (c5)
      return MODE_MUL;
    else if (shift_left)
      return MODE_SHL;
    else
      return MODE_SHR;
  endfunction

endpackage

// File: rtl/timing_ctrl_seq_if.sv
// Order/status and timing-pulse bundle between main control and the sequencer.
interface timing_ctrl_seq_if
  import edsac_timing_pkg::*;
#(
  parameter int MC_LEN   = MC_LEN_DEFAULT,
  parameter int STEP_MAX = STEP_MAX_DEFAULT
);

  localparam int CW = $clog2(STEP_MAX + 1);
  localparam int DW = $clog2(MC_LEN);

  logic          zero_d0;
  logic          c5;
  logic          c6;
  logic          shift_left;
  logic [CW-1:0] step_count;
  logic          d35;

  logic [DW-1:0] digit;
  logic          dx;
  logic          da;
  logic          dy;
  logic          g2_pos;
  logic          g2_neg;
  logic          shl;
  logic          seventy_d35;
  logic [CW-1:0] step_idx;
  logic          busy;
  logic          done;

  modport master (
    output zero_d0, c5, c6, shift_left, step_count, d35,
    input  digit, dx, da, dy, g2_pos, g2_neg, shl, seventy_d35,
           step_idx, busy, done
  );

  modport slave (
    input  zero_d0, c5, c6, shift_left, step_count, d35,
    output digit, dx, da, dy, g2_pos, g2_neg, shl, seventy_d35,
           step_idx, busy, done
  );

endinterface

// File: rtl/timing_ctrl_seq_digit_counter.sv
// Free-running mod-MC_LEN pulse-interval counter with wrap flag and look-ahead.
module digit_counter #(
  parameter int MC_LEN = 36
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [$clog2(MC_LEN)-1:0] digit,
  output logic [$clog2(MC_LEN)-1:0] digit_nxt,
  output logic                      wrap
);

  localparam int DW = $clog2(MC_LEN);

  assign wrap      = (digit == DW'(MC_LEN - 1));
  assign digit_nxt = wrap ? '0 : digit + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      digit <= '0;
    else
      digit <= digit_nxt;
  end

endmodule

// File: rtl/timing_ctrl_seq.sv
// Step sequencer generating dx/da/dy test pulses and the g2 gate for
// multiply and shift orders, one PH_A/PH_B minor-cycle pair per step.
module timing_ctrl_seq
  import edsac_timing_pkg::*;
#(
  parameter int MC_LEN   = MC_LEN_DEFAULT,
  parameter int STEP_MAX = STEP_MAX_DEFAULT,
  parameter int CW       = $clog2(STEP_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  timing_ctrl_seq_if.slave   bus
);

  localparam int DW = $clog2(MC_LEN);

  if (MC_LEN < 2 || STEP_MAX < 1 || STEP_MAX > MC_LEN - 1) begin : g_bad_params
    $error("timing_ctrl_seq: need MC_LEN >= 2 and 1 <= STEP_MAX <= MC_LEN-1");
  end

  logic [DW-1:0] digit;
  logic [DW-1:0] digit_nxt;
  logic          wrap;

  digit_counter #(.MC_LEN(MC_LEN)) u_digit (
    .clk       (clk),
    .rst       (rst),
    .digit     (digit),
    .digit_nxt (digit_nxt),
    .wrap      (wrap)
  );

  state_e        state, state_d;
  mode_e         mode, mode_d;
  logic [CW-1:0] s_q, s_d;
  logic [CW-1:0] n_q, n_d;
  logic          done_d;
  logic          start;
  logic [CW-1:0] n_clamp;
  logic [DW-1:0] s_ext;

  logic dx_q, da_q, dy_q, g2p_q, g2n_q, shl_q, seventy_q, busy_q, done_q;

  assign start   = (state == ST_IDLE) && (digit == '0) && bus.zero_d0 && (bus.c5 || bus.c6);
  assign n_clamp = (bus.step_count > CW'(STEP_MAX)) ? CW'(STEP_MAX) : bus.step_count;
  assign s_ext   = DW'(s_d);

  always_comb begin
    state_d = state;
    mode_d  = mode;
    s_d     = s_q;
    n_d     = n_q;
    done_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          mode_d  = decode_mode(bus.c5, bus.shift_left);
          n_d     = bus.c5 ? CW'(STEP_MAX) : n_clamp;
          s_d     = '0;
        end
      end
      ST_WAIT: begin
        if (wrap) begin
          if (n_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PH_A;
            s_d     = '0;
          end
        end
      end
      ST_PH_A: begin
        if (wrap)
          state_d = ST_PH_B;
      end
      ST_PH_B: begin
        if (wrap) begin
          if (s_q + 1'b1 == n_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PH_A;
            s_d     = s_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state/next-digit so they line up with
  // the cycle in which the state and digit actually hold those values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_MUL;
      s_q       <= '0;
      n_q       <= '0;
      dx_q      <= 1'b0;
      da_q      <= 1'b0;
      dy_q      <= 1'b0;
      g2p_q     <= 1'b0;
      g2n_q     <= 1'b1;
      shl_q     <= 1'b0;
      seventy_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      mode      <= mode_d;
      s_q       <= s_d;
      n_q       <= n_d;
      dx_q      <= (state_d == ST_PH_A) && (mode_d == MODE_MUL) && (digit_nxt == s_ext);
      da_q      <= (state_d == ST_PH_B) && (digit_nxt == s_ext);
      dy_q      <= (state_d == ST_PH_B) && (digit_nxt == s_ext + 1'b1);
      g2p_q     <= (state_d == ST_PH_A);
      g2n_q     <= (state_d != ST_PH_A);
      shl_q     <= (state_d != ST_IDLE) && (mode_d == MODE_SHL);
      seventy_q <= (state_d == ST_PH_A) && (digit_nxt == '0);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
    end
  end

  assign bus.digit       = digit;
  assign bus.dx          = dx_q;
  assign bus.da          = da_q;
  assign bus.dy          = dy_q;
  assign bus.g2_pos      = g2p_q;
  assign bus.g2_neg      = g2n_q;
  assign bus.shl         = shl_q;
  assign bus.seventy_d35 = seventy_q & bus.d35;
  assign bus.step_idx    = s_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_timing_ctrl_seq.sv
// Bench for timing_ctrl_seq: two configurations, per-cycle reference model,
// table-driven order runs and hand-written reset / ignored-start sequences.
module tb_timing_ctrl_seq;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  timing_ctrl_seq_if #(.MC_LEN(36), .STEP_MAX(35)) ifa ();
  timing_ctrl_seq_if #(.MC_LEN(8),  .STEP_MAX(7))  ifb ();

  timing_ctrl_seq #(.MC_LEN(36), .STEP_MAX(35)) u_a (.clk(clk), .rst(rst_a), .bus(ifa));
  timing_ctrl_seq #(.MC_LEN(8),  .STEP_MAX(7))  u_b (.clk(clk), .rst(rst_b), .bus(ifb));

  int checks = 0;
  int passes = 0;
  int cyc_fail_prints = 0;
  bit chk_en = 1'b0;

  // reference model state: start cycle, latched mode and step count
  int mcv[2]  = '{36, 8};
  int smax[2] = '{35, 7};
  int cyc[2]  = '{0, 0};
  int c0[2]   = '{0, 0};
  int nn[2]   = '{0, 0};
  bit act_m[2] = '{1'b0, 1'b0};
  bit mul_m[2] = '{1'b0, 1'b0};
  bit shl_m[2] = '{1'b0, 1'b0};

  typedef struct {
    int dut; int c5; int c6; int sl; int sc;
    int lat; int ndx; int nda; int ndy; int ng2; int nshl; int lastdy;
  } vec_t;
  vec_t vecs[8];

  function automatic logic rst_of(input int i);
    return (i == 0) ? rst_a : rst_b;
  endfunction

  function automatic logic [31:0] get_out(input int i);
    if (i == 0)
      return {8'(ifa.digit), 8'(ifa.step_idx), 7'b0, ifa.done, ifa.busy, ifa.seventy_d35,
              ifa.shl, ifa.g2_neg, ifa.g2_pos, ifa.dy, ifa.da, ifa.dx};
    else
      return {8'(ifb.digit), 8'(ifb.step_idx), 7'b0, ifb.done, ifb.busy, ifb.seventy_d35,
              ifb.shl, ifb.g2_neg, ifb.g2_pos, ifb.dy, ifb.da, ifb.dx};
  endfunction

  task automatic drive(input int i, input logic z, input logic c5v, input logic c6v,
                       input logic slv, input int scv);
    if (i == 0) begin
      ifa.zero_d0 = z; ifa.c5 = c5v; ifa.c6 = c6v; ifa.shift_left = slv; ifa.step_count = 6'(scv);
    end else begin
      ifb.zero_d0 = z; ifb.c5 = c5v; ifb.c6 = c6v; ifb.shift_left = slv; ifb.step_count = 3'(scv);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int lat_of(input int i);
    return mcv[i] * (1 + 2 * nn[i]);
  endfunction

  // Model edge: accept a start from the spec rules, then advance the cycle count.
  task automatic model_edge(input int i);
    logic z, c5v, c6v, slv;
    int scv;
    if (i == 0) begin
      z = ifa.zero_d0; c5v = ifa.c5; c6v = ifa.c6; slv = ifa.shift_left; scv = int'(ifa.step_count);
    end else begin
      z = ifb.zero_d0; c5v = ifb.c5; c6v = ifb.c6; slv = ifb.shift_left; scv = int'(ifb.step_count);
    end
    if (rst_of(i)) begin
      cyc[i] = 0;
      act_m[i] = 1'b0;
    end else begin
      if ((cyc[i] % mcv[i] == 0) && (!act_m[i] || cyc[i] - c0[i] >= lat_of(i)) &&
          z && (c5v || c6v)) begin
        act_m[i] = 1'b1;
        c0[i]    = cyc[i];
        mul_m[i] = c5v;
        shl_m[i] = slv && !c5v;
        nn[i]    = c5v ? smax[i] : ((scv > smax[i]) ? smax[i] : scv);
      end
      cyc[i]++;
    end
  endtask

  task automatic calc_exp(input int i, input logic d35v, output logic [31:0] e, output logic [31:0] m);
    int rel, L, k, s, ph, d;
    logic busy, done, g2p, dx, da, dy, sev, shl;
    logic in_ph;
    if (rst_of(i)) begin
      e = 32'h0000_0010;
      m = 32'hFFFF_FFFF;
      return;
    end
    rel = cyc[i] - c0[i];
    L = lat_of(i);
    busy = act_m[i] && rel >= 1 && rel <= L - 1;
    done = act_m[i] && rel == L;
    in_ph = busy && rel >= mcv[i];
    s = 0; g2p = 0; dx = 0; da = 0; dy = 0; sev = 0;
    if (in_ph) begin
      k  = rel - mcv[i];
      s  = k / (2 * mcv[i]);
      ph = (k % (2 * mcv[i])) / mcv[i];
      d  = k % mcv[i];
      g2p = (ph == 0);
      dx  = mul_m[i] && ph == 0 && d == s;
      da  = ph == 1 && d == s;
      dy  = ph == 1 && d == s + 1;
      sev = d35v && ph == 0 && d == 0;
    end
    shl = busy && shl_m[i];
    e = {8'(cyc[i] % mcv[i]), 8'(s), 7'b0, done, busy, sev, shl, ~g2p, g2p, dy, da, dx};
    m = {8'hFF, in_ph ? 8'hFF : 8'h00, 7'b0, 1'b1, 1'b1, 1'b1, busy, 5'h1F};
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  always @(posedge clk) begin
    #1;
    ifa.d35 = 1'($urandom_range(0, 1));
    ifb.d35 = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [31:0] e, m, a;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        calc_exp(i, (i == 0) ? ifa.d35 : ifb.d35, e, m);
        a = get_out(i);
        checks++;
        if ((a & m) == (e & m)) passes++;
        else if (cyc_fail_prints < 30) begin
          cyc_fail_prints++;
          $display("FAIL cycle dut%0d cyc=%0d: got %h, expected %h (mask %h)", i, cyc[i], a, e, m);
        end
      end
    end
  end

  task automatic wait_digit(input int i, input int dg);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((cyc[i] % mcv[i] != dg) && guard < 200);
  endtask

  // Runs one order and counts pulses; inputs are scrambled while it is busy.
  task automatic run_vec(input vec_t v, input string name);
    int c0s, rel, lat, ndx, nda, ndy, ng2, nshl, lastdy;
    logic [31:0] o;
    int i = v.dut;
    lat = -1; ndx = 0; nda = 0; ndy = 0; ng2 = 0; nshl = 0; lastdy = -1;
    drive(i, 0, 0, 0, 0, 0);
    wait_digit(i, 0);
    drive(i, 1, 1'(v.c5), 1'(v.c6), 1'(v.sl), v.sc);
    c0s = cyc[i];
    for (int t = 0; t < v.lat + 40; t++) begin
      @(posedge clk); #1;
      o = get_out(i);
      rel = cyc[i] - c0s;
      if (o[8]) begin
        lat = rel;
        break;
      end
      ndx += int'(o[0]);
      nda += int'(o[1]);
      if (o[2]) begin ndy++; lastdy = int'(o[31:24]); end
      ng2 += int'(o[3]);
      if (o[5] && o[7]) nshl++;
      if (rel <= v.lat - 1)
        drive(i, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
      else
        drive(i, 0, 0, 0, 0, 0);
    end
    drive(i, 0, 0, 0, 0, 0);
    check({name, " latency"}, lat, v.lat);
    check({name, " dx count"}, ndx, v.ndx);
    check({name, " da count"}, nda, v.nda);
    check({name, " dy count"}, ndy, v.ndy);
    check({name, " g2 cycles"}, ng2, v.ng2);
    check({name, " shl cycles"}, nshl, v.nshl);
    if (v.lastdy >= 0) check({name, " last dy digit"}, lastdy, v.lastdy);
  endtask

  initial begin
    int c0s, nbusy, ndone;
    vecs[0] = '{0, 1, 0, 0, 0,  2556, 35, 35, 35, 1260, 0,   35};
    vecs[1] = '{0, 0, 1, 0, 3,  252,  0,  3,  3,  108,  0,   3};
    vecs[2] = '{0, 0, 1, 1, 0,  36,   0,  0,  0,  0,    35,  -1};
    vecs[3] = '{0, 1, 1, 1, 2,  2556, 35, 35, 35, 1260, 0,   35};
    vecs[4] = '{0, 0, 1, 0, 40, 2556, 0,  35, 35, 1260, 0,   35};
    vecs[5] = '{0, 0, 1, 1, 1,  108,  0,  1,  1,  36,   107, 1};
    vecs[6] = '{1, 0, 1, 0, 7,  120,  0,  7,  7,  56,   0,   7};
    vecs[7] = '{1, 1, 0, 0, 0,  120,  7,  7,  7,  56,   0,   7};

    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    ifa.d35 = 1'b0;
    ifb.d35 = 1'b0;
    #2 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset g2_neg", int'(ifa.g2_neg), 1);
    check("reset busy", int'(ifa.busy), 0);
    check("reset digit", int'(ifa.digit), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int v = 0; v < 8; v++)
      run_vec(vecs[v], $sformatf("vec%0d", v));

    // start request away from digit 0 must be ignored
    wait_digit(0, 5);
    drive(0, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    nbusy = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      nbusy += int'(ifa.busy);
    end
    check("digit5 start ignored", nbusy, 0);

    // reset during PH_B of step 2, then a clean restart
    wait_digit(0, 0);
    drive(0, 1, 0, 1, 0, 5);
    c0s = cyc[0];
    for (int t = 0; t < 300 && cyc[0] - c0s != 219; t++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0);
    end
    check("pre-reset step_idx", int'(ifa.step_idx), 2);
    rst_a = 1'b1;
    #1;
    check("midreset g2_neg", int'(ifa.g2_neg), 1);
    check("midreset busy", int'(ifa.busy), 0);
    check("midreset digit", int'(ifa.digit), 0);
    ndone = 0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      ndone += int'(ifa.done);
    end
    rst_a = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      ndone += int'(ifa.done);
    end
    check("no done after reset", ndone, 0);
    run_vec(vecs[5], "restart");

    // random orders on both configurations, checked cycle by cycle by the model
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      drive(0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4)));
      drive(1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/timing_ctrl_seq.md
Name: timing_ctrl_seq

Overview:
Parametrised successor of the timing control tank / shifting unit in the control section. It replaces the recirculating 1 M/C tank with a digit counter and a step sequencer. It generates the staggered dx/da/dy test pulses and the g2 gate for multiply (V/N), right shift (R) and left shift (L) orders. Unlike the previous unit, it supports a variable step count, explicit shift direction, and busy/done status toward the main control.

Parameters:
MC_LEN, 36, pulse intervals (p.i.) per minor cycle; digit counter modulus.
STEP_MAX, 35, maximum steps per order; must satisfy 1 <= STEP_MAX <= MC_LEN-1 (elaboration error otherwise).
CW, $clog2(STEP_MAX+1), width of step count/index.

Ports:
clk  in  1  p.i. clock.
rst  in  1  asynchronous, active-high reset.
zero_d0  in  1  start request from CCU 2; honoured only when digit==0.
c5  in  1  multiply order (V/N).
c6  in  1  shift order (R/L).
shift_left  in  1  1=L, 0=R; sampled with the start request.
step_count  in  CW  shift step count; ignored for multiply.
d35  in  1  digit-35 timing pulse.
digit  out  $clog2(MC_LEN)  current p.i. within the minor cycle.
dx  out  1  multiplier digit test pulse (multiply only).
da  out  1  sign test pulse.
dy  out  1  reset pulse after partial-product add / shift step.
g2_pos  out  1  multiplicand/shift gate.
g2_neg  out  1  always ~g2_pos.
shl  out  1  latched direction: left shift active.
seventy_d35  out  1  d35 qualified by step start.
step_idx  out  CW  current step s.
busy  out  1  order in progress.
done  out  1  one-clock completion pulse.

Behaviour:
- Reset values (asynchronous): digit=0, state IDLE, g2_pos=0, g2_neg=1, all pulses 0, shl=0, step_idx=0, busy=0, done=0.
- digit: free-running counter 0..MC_LEN-1, wraps to 0.
- Start is accepted when all of the following hold: state IDLE, digit==0, zero_d0=1, and (c5|c6).
  - Mode is latched at that edge. c5 has priority over c6 (MUL over SHIFT).
  - N = STEP_MAX for MUL; N = min(step_count, STEP_MAX) for SHIFT.
  - shl is latched as shift_left & ~c5.
- zero_d0 while busy or at digit!=0 is ignored.
- States:
  - IDLE -> WAIT on start.
  - WAIT holds for the remainder of the start minor cycle (1 M/C latency, matching the old 72 us tank). At digit wrap it goes to PH_A with s=0.
  - PH_A lasts one minor cycle. g2_pos=1. dx=1 in the clock where digit==s, MUL mode only. seventy_d35=d35 while digit==0. At digit==MC_LEN-1 it goes to PH_B.
  - PH_B lasts one minor cycle. g2_pos=0. da=1 at digit==s. dy=1 at digit==s+1 (always within the cycle, given the STEP_MAX bound). At digit==MC_LEN-1:
    - if s+1==N: done=1 for the next clock, state IDLE;
    - else: s increments and the state goes to PH_A.
- SHIFT with N==0: no PH_A/PH_B; done pulses in the first clock after WAIT ends; no g2/dx/da/dy.
- busy=1 in WAIT/PH_A/PH_B. done occurs in the clock after busy falls. A new start may be accepted at the next digit==0.
- Pulses are decoded from registered state and digit only, so there is no combinational path from inputs to dx/da/dy/g2. The exception is seventy_d35, which gates the live d35.
- A reset asserted mid-order returns everything to reset values immediately; no done pulse is produced.
- Inputs c5/c6/shift_left/step_count changing after start have no effect.

Decomposition:
- Package edsac_timing_pkg:
  - mode enum {MODE_MUL, MODE_SHR, MODE_SHL};
  - state enum {ST_IDLE, ST_WAIT, ST_PH_A, ST_PH_B};
  - default MC_LEN=36.
- Sub-module digit_counter (mod-MC_LEN counter, async active-high reset, outputs digit and wrap flag). It is reusable by other minor-cycle timed units.

Test Plan:
- Defaults. MUL: zero_d0+c5 at digit 0 -> busy next clock. PH_A starts at clock 36, dx at clock 36+s+72s for s=0..34, da/dy at digits s and s+1 of each PH_B. done 1 clock after the 71st M/C boundary (35 steps).
- SHIFT R, step_count=3 -> exactly 3 PH_A/PH_B pairs. No dx. dy at digits 1,2,3 of successive PH_B. shl=0. done once.
- SHIFT L, step_count=0 -> done pulse at clock 36, no g2_pos/da/dy, shl=1 while busy.
- zero_d0 at digit 5 or while busy is ignored. c5&c6 together takes the MUL path. step_count=40 (CW=6) clamps to 35 steps.
- MC_LEN=8, STEP_MAX=7, SHIFT step_count=7 -> final dy at digit 7 of the last PH_B. Digit wraps cleanly and done follows.
- rst asserted during PH_B of step 2 -> g2_neg=1, busy=0, no done. A restart at the next digit 0 runs normally.
